// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler slice:
//   state_t     - scheduler FSM encoding (IDLE/LOAD/WAIT_ACK/WAIT_DONE)
//   DATA_W_DEF  - default byte width driven to the tx engine
//   clog2()     - ceiling log2, used for index and counter widths
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 8;

    // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the winner is the first set bit of
// req at or after ptr, wrapping from NREQ-1 back to 0.
// Ports:
//   req    in   NREQ    request vector
//   ptr    in   IDX_W   index with highest priority this cycle (< NREQ)
//   grant  out  NREQ    one-hot winner (all zero when no request)
//   idx    out  IDX_W   binary index of the winner (0 when no request)
//   any    out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART byte transmitter among NREQ byte sources. Round-robin
// arbitration in IDLE (gated by cts and an idle engine), then a start/busy
// handshake with the tx engine: LOAD pulses tx_start, WAIT_ACK waits up to
// ACK_TO cycles for tx_busy to rise (else err_timeout and the byte is
// dropped), WAIT_DONE waits for tx_busy to fall.
//
// Handshake: a byte moves from requester i when req_valid[i] & req_ready[i]
// are both high on a rising clk edge. req_ready is combinational, at most one
// bit high, and only ever high in IDLE; a requester that drops req_valid
// before that edge is simply not granted.
//
// Optional feature macro: UART_PKT_LOCK_EN
//   defined   - a byte accepted with req_last=0 locks arbitration to its
//               requester until a req_last=1 byte is accepted or a timeout.
//   undefined - req_last is ignored; arbitration rotates every byte.
//
// Ports:
//   clk          in   1              rising-edge clock
//   rst          in   1              asynchronous active-high reset
//   req_valid    in   NREQ           requester i has a byte pending
//   req_data     in   NREQ*DATA_W    byte of requester i at [i*DATA_W +: DATA_W]
//   req_last     in   NREQ           byte ends a packet (lock feature only)
//   req_ready    out  NREQ           one-hot accept
//   cts          in   1              clear-to-send, sampled only in IDLE
//   tx_busy      in   1              tx engine shifting a byte
//   tx_start     out  1              one-cycle load pulse to the engine
//   tx_data      out  DATA_W         byte to transmit, held until next accept
//   grant_id     out  clog2(NREQ)    index of last accepted requester
//   sched_busy   out  1              scheduler not in IDLE
//   err_timeout  out  1              one-cycle pulse when tx_busy never rose
//   dbg_state    out  state_t        current FSM state
// -----------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACK_TO = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     cts,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     sched_busy,
    output logic                     err_timeout,
    output state_t                   dbg_state
);

    localparam int IDX_W = clog2(NREQ);
    localparam int CNT_W = clog2(ACK_TO) + 1;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] ack_cnt;

    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             can_accept;
    logic             transfer;

    // -------------------------------------------------------------------------
    // Arbitration request mask (packet lock)
    // -------------------------------------------------------------------------
`ifdef UART_PKT_LOCK_EN
    logic             lock_active;
    logic [IDX_W-1:0] lock_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_idx    <= '0;
        end else if (err_timeout) begin
            lock_active <= 1'b0;
        end else if (transfer) begin
            lock_active <= !req_last[arb_idx];
            lock_idx    <= arb_idx;
        end
    end

    // While locked, only the owning requester is visible to the arbiter; an
    // idle owner therefore stalls the scheduler indefinitely.
    assign arb_req = lock_active ? (req_valid & (NREQ'(1) << lock_idx)) : req_valid;
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign arb_req     = req_valid;
`endif

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // A new byte may only start from IDLE with the line clear and the engine idle.
    assign can_accept = (state == ST_IDLE) && cts && !tx_busy;
    assign transfer   = can_accept && arb_any;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        req_ready   = '0;
        tx_start    = 1'b0;
        err_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (can_accept) begin
                    req_ready = arb_grant;
                    if (arb_any) begin
                        state_nx = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                tx_start = 1'b1;
                state_nx = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_nx = ST_WAIT_DONE;
                end else if (ack_cnt == CNT_W'(ACK_TO - 1)) begin
                    // Byte is dropped, not retried; the pointer already moved on.
                    err_timeout = 1'b1;
                    state_nx    = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign sched_busy = (state != ST_IDLE);
    assign dbg_state  = state;

    // -------------------------------------------------------------------------
    // Data latch, grant index, round-robin pointer, ack counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data  <= '0;
            grant_id <= '0;
            ptr      <= '0;
            ack_cnt  <= '0;
        end else begin
            if (transfer) begin
                tx_data  <= req_data[int'(arb_idx) * DATA_W +: DATA_W];
                grant_id <= arb_idx;
                ptr      <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            end
            // Counter starts at zero on the first WAIT_ACK cycle, so the
            // timeout lands exactly ACK_TO cycles after the tx_start pulse.
            if (state == ST_LOAD) begin
                ack_cnt <= '0;
            end else if (state == ST_WAIT_ACK) begin
                ack_cnt <= ack_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Directed scenarios followed by randomized traffic, checked every cycle
// against a timeline model: the model only knows when the scheduler becomes
// free again after each accept (engine byte time + 3, or ACK_TO + 2 on a
// timeout), which requester the round-robin rule picks, and which byte must
// appear at each tx_start.
// Optional feature macro: UART_PKT_LOCK_EN (adds packet-lock expectations).
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int ACK_TO = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   cts;
  logic                   tx_busy;
  logic                   tx_start;
  logic [DATA_W-1:0]      tx_data;
  logic [1:0]             grant_id;
  logic                   sched_busy;
  logic                   err_timeout;
  state_t                 dbg_state;

  uart_tx_sched #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .ACK_TO (ACK_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .cts         (cts),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // counters
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  int  cyc       = 0;
  int  ptr       = 0;
  int  free_at   = 0;
  int  start_at  = -1;
  int  to_at     = -1;
  int  exp_gid   = 0;
  int  acc_count = 0;
  bit  lock_on   = 1'b0;
  int  lock_idx  = 0;
  logic [DATA_W-1:0] exp_q[$];
  int  gid_log[$];

  // engine model / stimulus knobs
  bit  start_seen = 1'b0;
  int  eng_rem    = 0;
  int  cur_bt     = 1;
  bit  cur_en     = 1'b1;
  int  bt_next    = 4;
  bit  eng_en     = 1'b1;
  bit  refill     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: runs the engine model, checks outputs mid-cycle against
  // the model, advances the model, then lets the edge happen.
  task automatic step();
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] exp_ready;
    int win;
    int j;
    if (start_seen) begin
      start_seen = 1'b0;
      if (cur_en) begin
        tx_busy = 1'b1;
        eng_rem = cur_bt - 1;
      end
    end else if (eng_rem > 0) begin
      eng_rem--;
    end else begin
      tx_busy = 1'b0;
    end
    #1;
    elig = req_valid;
    if (lock_on) elig = req_valid & (NREQ'(1) << lock_idx);
    exp_ready = '0;
    win = -1;
    if (cyc >= free_at && cts && !tx_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (ptr + k) % NREQ;
        if (win < 0 && elig[j]) win = j;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("ready_onehot0", 32'($onehot0(req_ready)), 1);
    check("tx_start", 32'(tx_start), 32'(cyc == start_at));
    check("err_timeout", 32'(err_timeout), 32'(cyc == to_at));
    check("sched_busy", 32'(sched_busy), 32'(cyc < free_at));
    if (cyc == start_at) begin
      gid_log.push_back(int'(grant_id));
      check("grant_id", 32'(grant_id), 32'(exp_gid));
      check("tx_data_queued", 32'(exp_q.size()), 1);
      if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      start_seen = 1'b1;
    end
    if (win >= 0) begin
      exp_q.push_back(req_data[win*DATA_W +: DATA_W]);
      exp_gid  = win;
      ptr      = (win + 1) % NREQ;
      start_at = cyc + 1;
      cur_bt   = bt_next;
      cur_en   = eng_en;
      acc_count++;
      if (eng_en) begin
        free_at = cyc + 3 + bt_next;
        to_at   = -1;
      end else begin
        free_at = cyc + 2 + ACK_TO;
        to_at   = cyc + 1 + ACK_TO;
      end
`ifdef UART_PKT_LOCK_EN
      lock_on  = eng_en && !req_last[win];
      lock_idx = win;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    if (win >= 0) begin
      if (refill) req_data[win*DATA_W +: DATA_W] = DATA_W'($urandom);
      else req_valid[win] = 1'b0;
    end
  endtask

  // Reset pulse landing between clock edges; outputs must clear at once.
  task automatic apply_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_sched_busy", 32'(sched_busy), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    req_valid  = '0;
    tx_busy    = 1'b0;
    eng_rem    = 0;
    start_seen = 1'b0;
    ptr        = 0;
    free_at    = 0;
    start_at   = -1;
    to_at      = -1;
    lock_on    = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
  endtask

  int target;
  int guard;
  int fair_exp[5] = '{0, 1, 2, 3, 0};
`ifdef UART_PKT_LOCK_EN
  logic [7:0] lock_bytes[3] = '{8'h10, 8'h11, 8'h12};
  int lock_exp[4] = '{2, 2, 2, 0};
`endif

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    cts       = 1'b1;
    tx_busy   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_req_ready", 32'(req_ready), 0);
    check("init_tx_start", 32'(tx_start), 0);
    check("init_tx_data", 32'(tx_data), 0);
    check("init_grant_id", 32'(grant_id), 0);
    check("init_sched_busy", 32'(sched_busy), 0);
    check("init_err_timeout", 32'(err_timeout), 0);
    rst = 1'b0;
    cyc = 1;

    // single byte from requester 0
    req_valid = 4'b0001;
    req_data[7:0] = 8'h41;
    bt_next = 4;
    step();
    repeat (10) step();

    // reset while the engine is shifting (WAIT_DONE)
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    bt_next = 8;
    repeat (4) step();
    check("mid_byte_busy", 32'(sched_busy), 1);
    apply_reset();

    // fairness: all requesters valid continuously, 10-cycle engine
    gid_log.delete();
    refill = 1'b1;
    bt_next = 10;
    for (int r = 0; r < NREQ; r++) req_data[r*DATA_W +: DATA_W] = DATA_W'($urandom);
    req_valid = 4'b1111;
    target = acc_count + 5;
    guard = 0;
    while (acc_count < target && guard < 120) begin
      step();
      guard++;
    end
    check("fair_wait", 32'(guard < 120), 1);
    req_valid = '0;
    refill = 1'b0;
    repeat (20) step();
    check("fair_count", 32'(gid_log.size()), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gid_log.size()) check("fair_order", 32'(gid_log[i]), 32'(fair_exp[i]));
    end

    // clear-to-send held low, then released
    cts = 1'b0;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h5A;
    repeat (50) step();
    cts = 1'b1;
    #1;
    check("cts_ready_same_cycle", 32'(req_ready), 32'(4'b0010));
    step();
    repeat (20) step();

    // engine never answers: timeout
    eng_en = 1'b0;
    req_valid = 4'b0001;
    req_data[7:0] = 8'hC3;
    step();
    eng_en = 1'b1;
    repeat (ACK_TO + 4) step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req_valid[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[r] = 1'b1;
            req_data[r*DATA_W +: DATA_W] = DATA_W'($urandom);
            req_last[r] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      cts = ($urandom_range(0, 7) != 0);
      bt_next = $urandom_range(1, 6);
      eng_en = ($urandom_range(0, 19) != 0);
      step();
    end
    req_valid = '0;
    cts = 1'b1;
    eng_en = 1'b1;
    repeat (ACK_TO + 20) step();

`ifdef UART_PKT_LOCK_EN
    // packet lock: requester 2 sends three bytes while requester 0 waits
    apply_reset();
    gid_log.delete();
    bt_next = 3;
    req_last = '0;
    for (int b = 0; b < 3; b++) begin
      req_valid[2] = 1'b1;
      req_data[23:16] = lock_bytes[b];
      req_last[2] = (b == 2);
      if (b > 0) begin
        req_valid[0] = 1'b1;
        req_data[7:0] = 8'h55;
        req_last[0] = 1'b1;
      end
      target = acc_count + 1;
      guard = 0;
      while (acc_count < target && guard < 60) begin
        step();
        guard++;
      end
      check("lock_wait", 32'(guard < 60), 1);
    end
    target = acc_count + 1;
    guard = 0;
    while (acc_count < target && guard < 60) begin
      step();
      guard++;
    end
    check("lock_release_wait", 32'(guard < 60), 1);
    req_valid = '0;
    repeat (15) step();
    check("lock_count", 32'(gid_log.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gid_log.size()) check("lock_order", 32'(gid_log[i]), 32'(lock_exp[i]));
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
